// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: rotating column strobe, synchronized row
// sampling, per-scan ghost rejection and press/release debounce with a one-cycle valid.
module keypad_scanner #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int             PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [3:0]     DB_COUNT   = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        PRESSED  = 2'd2,
        REL_DB   = 2'd3
    } state_t;

    function automatic logic [2:0] count_low(input logic [3:0] v);
        logic [2:0] c;
        c = 3'd0;
        for (int i = 0; i < 4; i++) begin
            c = c + {2'b00, ~v[i]};
        end
        return c;
    endfunction

    function automatic logic [1:0] last_low_idx(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!v[i]) begin
                idx = i[1:0];
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    logic [3:0]    sync1_q, sync2_q;
    logic [PW-1:0] presc_q;
    logic [1:0]    col_idx_q;
    logic [3:0]    col_n_q;
    logic [1:0]    acc_cnt_q;
    logic [3:0]    acc_code_q;
    state_t        state_q, state_d;
    logic [3:0]    cand_q, cand_d;
    logic [3:0]    stable_q, stable_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_down_q, key_down_d;

    logic          sample_s, close_s;
    logic [2:0]    col_cnt_s, sum_s;
    logic [1:0]    total_s;
    logic [3:0]    scan_code_s, stable_inc_s;
    logic          res_none_s, res_single_s;

    // Two-flop synchronizer for the asynchronous row inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 4'b1111;
            sync2_q <= 4'b1111;
        end else begin
            sync1_q <= row_n;
            sync2_q <= sync1_q;
        end
    end

    // Prescaler and rotating column select; column advances at each sample point
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q   <= '0;
            col_idx_q <= 2'd0;
            col_n_q   <= 4'b1110;
        end else if (sample_s) begin
            presc_q   <= '0;
            col_idx_q <= col_idx_q + 2'd1;
            col_n_q   <= ~(4'b0001 << (col_idx_q + 2'd1));
        end else begin
            presc_q   <= presc_q + PW'(1);
        end
    end

    // Per-column pressed count, saturated at 2 since only NONE/SINGLE/MULTI matter
    always_comb begin
        sample_s     = (presc_q == PRESC_LAST);
        close_s      = sample_s && (col_idx_q == 2'd3);
        col_cnt_s    = count_low(sync2_q);
        sum_s        = {1'b0, acc_cnt_q} + col_cnt_s;
        total_s      = (sum_s >= 3'd2) ? 2'd2 : sum_s[1:0];
        scan_code_s  = (col_cnt_s != 3'd0) ? {last_low_idx(sync2_q), col_idx_q} : acc_code_q;
        res_none_s   = close_s && (total_s == 2'd0);
        res_single_s = close_s && (total_s == 2'd1);
        stable_inc_s = stable_q + 4'd1;
    end

    // Scan accumulators, cleared when a scan closes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt_q  <= 2'd0;
            acc_code_q <= 4'd0;
        end else if (close_s) begin
            acc_cnt_q  <= 2'd0;
            acc_code_q <= 4'd0;
        end else if (sample_s) begin
            acc_cnt_q  <= total_s;
            acc_code_q <= scan_code_s;
        end else begin
            acc_cnt_q  <= acc_cnt_q;
            acc_code_q <= acc_code_q;
        end
    end

    // Debounce FSM next state; MULTI counts as no press but also as no release
    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        stable_d    = stable_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (res_single_s) begin
                    cand_d   = scan_code_s;
                    stable_d = 4'd1;
                    if (DB_COUNT == 4'd1) begin
                        state_d     = PRESSED;
                        key_code_d  = scan_code_s;
                        key_valid_d = 1'b1;
                    end else begin
                        state_d = PRESS_DB;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            PRESS_DB: begin
                if (res_single_s && (scan_code_s == cand_q)) begin
                    stable_d = stable_inc_s;
                    if (stable_inc_s >= DB_COUNT) begin
                        state_d     = PRESSED;
                        key_code_d  = cand_q;
                        key_valid_d = 1'b1;
                    end else begin
                        state_d = PRESS_DB;
                    end
                end else if (res_single_s) begin
                    cand_d   = scan_code_s;
                    stable_d = 4'd1;
                end else if (close_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = PRESS_DB;
                end
            end
            PRESSED: begin
                if (res_none_s) begin
                    stable_d = 4'd1;
                    state_d  = (DB_COUNT == 4'd1) ? IDLE : REL_DB;
                end else begin
                    state_d = PRESSED;
                end
            end
            REL_DB: begin
                if (res_none_s) begin
                    stable_d = stable_inc_s;
                    state_d  = (stable_inc_s >= DB_COUNT) ? IDLE : REL_DB;
                end else if (close_s) begin
                    state_d = PRESSED;
                end else begin
                    state_d = REL_DB;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        key_down_d = (state_d == PRESSED) || (state_d == REL_DB);
    end

    // FSM state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cand_q      <= 4'd0;
            stable_q    <= 4'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            stable_q    <= stable_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
        end
    end

    assign col_n     = col_n_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model, scan-level run-length reference model,
// table-driven press cases, hand-written corner sequences and random key activity.
module tb_keypad_scanner;
    localparam int SD = 8;
    localparam int DB = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row_n, col_n, key_code;
    logic        key_valid, key_down;
    logic [15:0] keys = 16'd0;   // bit r*4+c = key at (row r, col c) held

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
        .clk(clk), .rst_n(rst_n), .row_n(row_n), .col_n(col_n),
        .key_code(key_code), .key_valid(key_valid), .key_down(key_down)
    );

    always #5 clk = ~clk;

    // A row reads low when any held key on it sits in a driven column
    assign row_n = { ~|(keys[15:12] & ~col_n), ~|(keys[11:8] & ~col_n),
                     ~|(keys[7:4]   & ~col_n), ~|(keys[3:0]  & ~col_n) };

    int checks = 0;
    int errors = 0;

    int          n, col_m, scan_cnt, run_len, none_len, pulses;
    logic [15:0] m_p1, m_p2;
    logic [3:0]  scan_code, run_code, exp_code, last_code;
    bit          held;
    logic        exp_valid;

    typedef struct {
        logic [15:0] k;
        int          hold;
        int          exp_pulses;
        logic [3:0]  exp_code;
    } vec_t;
    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        n = 0; col_m = 0; scan_cnt = 0; scan_code = 4'd0;
        m_p1 = 16'd0; m_p2 = 16'd0;
        held = 1'b0; run_len = 0; none_len = 0; run_code = 4'd0;
        exp_valid = 1'b0; exp_code = 4'd0;
    endtask

    // Debounce rules as run lengths of identical scan outcomes
    task automatic model_scan(input int cnt, input logic [3:0] code);
        if (!held) begin
            if (cnt == 1) begin
                if (run_len > 0 && run_code == code) run_len++;
                else begin run_len = 1; run_code = code; end
                if (run_len >= DB) begin
                    held = 1'b1; exp_valid = 1'b1; exp_code = code;
                    run_len = 0; none_len = 0;
                end
            end else run_len = 0;
        end else begin
            if (cnt == 0) begin
                none_len++;
                if (none_len >= DB) begin held = 1'b0; run_len = 0; end
            end else none_len = 0;
        end
    endtask

    // Rows are seen through two flops, so a sample uses the key state two edges back
    task automatic model_edge();
        logic [15:0] seen;
        n++;
        seen = m_p2; m_p2 = m_p1; m_p1 = keys;
        exp_valid = 1'b0;
        if (n % SD == 0) begin
            for (int r = 0; r < 4; r++) begin
                if (seen[r*4 + col_m]) begin
                    scan_cnt++;
                    scan_code = {r[1:0], col_m[1:0]};
                end
            end
            if (col_m == 3) begin
                model_scan(scan_cnt, scan_code);
                scan_cnt = 0;
            end
            col_m = (col_m + 1) % 4;
        end
    endtask

    task automatic tick();
        logic [3:0] exp_col;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        exp_col = ~(4'b0001 << col_m);
        check("col_n", {28'd0, col_n}, {28'd0, exp_col});
        check("key_valid", {31'd0, key_valid}, {31'd0, exp_valid});
        check("key_down", {31'd0, key_down}, {31'd0, held});
        check("key_code", {28'd0, key_code}, {28'd0, exp_code});
        if (key_valid === 1'b1) begin pulses++; last_code = key_code; end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_col_n", {28'd0, col_n}, 32'h0000000e);
        check("rst_key_valid", {31'd0, key_valid}, 32'd0);
        check("rst_key_down", {31'd0, key_down}, 32'd0);
        check("rst_key_code", {28'd0, key_code}, 32'd0);
        repeat (2) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    initial begin
        int lat, drops;
        logic [3:0] want_col;
        tbl[0] = '{16'h0200, 200, 1, 4'b1001};
        tbl[1] = '{16'h0008, 200, 1, 4'b0011};
        tbl[2] = '{16'h0001, 200, 1, 4'b0000};
        tbl[3] = '{16'h8000, 200, 1, 4'b1111};
        tbl[4] = '{16'h0041, 200, 0, 4'b0000};
        tbl[5] = '{16'h1410, 200, 0, 4'b0000};
        model_reset();
        pulses = 0; last_code = 4'd0;

        // Reset and idle column rotation
        apply_reset();
        for (int t = 1; t <= 40; t++) begin
            tick();
            want_col = ~(4'b0001 << ((t / SD) % 4));
            check("strobe_seq", {28'd0, col_n}, {28'd0, want_col});
        end
        check("idle_pulses", pulses, 0);

        // Clean press with bounded latency, then release
        keys = 16'h0200; lat = 0; pulses = 0;
        for (int t = 1; t <= 200; t++) begin
            tick();
            if (key_valid === 1'b1 && lat == 0) lat = t;
        end
        check("press_latency_ok", {31'd0, (lat > 0 && lat <= 131)}, 32'd1);
        check("press_pulses", pulses, 1);
        keys = 16'd0;
        repeat (200) tick();

        // Table of single, ghosted and multi-key holds
        for (int i = 0; i < 6; i++) begin
            pulses = 0;
            keys = tbl[i].k;
            repeat (tbl[i].hold) tick();
            keys = 16'd0;
            repeat (200) tick();
            check("tbl_pulses", pulses, tbl[i].exp_pulses);
            if (tbl[i].exp_pulses > 0) check("tbl_code", {28'd0, last_code}, {28'd0, tbl[i].exp_code});
        end

        // Bounce on row 0 / col 3, aligned to reset
        apply_reset();
        pulses = 0;
        for (int i = 0; i < 150; i++) begin
            if (i % 20 == 0) keys = keys ^ 16'h0008;
            tick();
        end
        check("bounce_pulses", pulses, 0);
        keys = 16'h0008;
        repeat (200) tick();
        check("bounce_hold_pulses", pulses, 1);
        check("bounce_code", {28'd0, last_code}, 32'h3);
        keys = 16'd0;
        repeat (200) tick();

        // Ghost pair, then drop one key
        pulses = 0;
        keys = 16'h0041;
        repeat (200) tick();
        check("ghost_pulses", pulses, 0);
        keys = 16'h0001;
        repeat (200) tick();
        check("ghost_release_pulses", pulses, 1);
        check("ghost_release_code", {28'd0, last_code}, 32'h0);
        keys = 16'd0;
        repeat (200) tick();

        // One-scan release glitch while held
        keys = 16'h0200;
        repeat (200) tick();
        pulses = 0; drops = 0;
        keys = 16'd0;
        for (int t = 0; t < 32; t++) begin tick(); if (key_down !== 1'b1) drops++; end
        keys = 16'h0200;
        for (int t = 0; t < 100; t++) begin tick(); if (key_down !== 1'b1) drops++; end
        check("glitch_drops", drops, 0);
        check("glitch_pulses", pulses, 0);
        keys = 16'd0;
        repeat (200) tick();

        // Reset in the middle of press debounce: three fresh scans needed afterwards
        apply_reset();
        keys = 16'h0200; pulses = 0;
        repeat (70) tick();
        check("middb_pulses", pulses, 0);
        apply_reset();
        lat = 0;
        for (int t = 1; t <= 130; t++) begin
            tick();
            if (key_valid === 1'b1 && lat == 0) lat = t;
        end
        check("middb_fresh_latency", lat, 96);
        keys = 16'd0;
        repeat (200) tick();

        // Random key activity against the reference model
        for (int s = 0; s < 40; s++) begin
            case ($urandom_range(0, 3))
                0:       keys = 16'd0;
                1, 2:    keys = 16'd1 << $urandom_range(0, 15);
                default: keys = (16'd1 << $urandom_range(0, 15)) | (16'd1 << $urandom_range(0, 15));
            endcase
            repeat ($urandom_range(20, 160)) tick();
        end
        keys = 16'd0;
        repeat (200) tick();
        check("final_released", {31'd0, key_down}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
